// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// dmem_arbiter_pkg: state encoding and default widths shared by the data-memory arbiter.
// Revision: 1.0
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_RESP = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: serialises pipeline loads and stores onto one request/accept/response bus
// and stalls the pipeline until every enabled request of the cycle is served. Revision: 1.0
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  R_EN,
  input  logic [ADDR_W-1:0]     R_ADDR,
  input  logic                  W_EN,
  input  logic [ADDR_W-1:0]     W_ADDR,
  input  logic [DATA_W/8-1:0]   W_STRB,
  input  logic [DATA_W-1:0]     W_DATA,
  output logic                  MEM_WAIT,
  output logic                  DATA_RVALID,
  output logic [ADDR_W-1:0]     DATA_ROADDR,
  output logic [DATA_W-1:0]     DATA_RDATA,
  output logic                  BUS_REQ,
  output logic                  BUS_WE,
  output logic [ADDR_W-1:0]     BUS_ADDR,
  output logic [DATA_W/8-1:0]   BUS_STRB,
  output logic [DATA_W-1:0]     BUS_WDATA,
  input  logic                  BUS_READY,
  input  logic                  BUS_RVALID,
  input  logic [DATA_W-1:0]     BUS_RDATA
);

  arb_state_t        state;
  logic              wr_served;
  logic              drop;
  logic [ADDR_W-1:0] rd_addr;

  logic dropping;
  logic wr_pending;
  logic rd_pending;

  // A load is pending until its data pulse; gating on DATA_RVALID also stops a
  // held R_EN from re-issuing the same load in its completion cycle.
  assign dropping   = drop || FLUSH;
  assign wr_pending = W_EN && !wr_served;
  assign rd_pending = R_EN && !DATA_RVALID;
  assign MEM_WAIT   = !dropping &&
                      (wr_pending || rd_pending || (W_EN && !R_EN && state == WR_REQ));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wr_served   <= 1'b0;
      drop        <= 1'b0;
      rd_addr     <= '0;
      DATA_RVALID <= 1'b0;
      DATA_ROADDR <= '0;
      DATA_RDATA  <= '0;
      BUS_REQ     <= 1'b0;
      BUS_WE      <= 1'b0;
      BUS_ADDR    <= '0;
      BUS_STRB    <= '0;
      BUS_WDATA   <= '0;
    end else begin
      DATA_RVALID <= 1'b0;

      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (wr_pending) begin
            state     <= WR_REQ;
            BUS_REQ   <= 1'b1;
            BUS_WE    <= 1'b1;
            BUS_ADDR  <= W_ADDR;
            BUS_STRB  <= W_STRB;
            BUS_WDATA <= W_DATA;
          end else if (rd_pending) begin
            state    <= RD_REQ;
            BUS_REQ  <= 1'b1;
            BUS_WE   <= 1'b0;
            BUS_ADDR <= R_ADDR;
            BUS_STRB <= '0;
            rd_addr  <= R_ADDR;
          end
        end

        WR_REQ: begin
          if (BUS_READY) begin
            wr_served <= 1'b1;
            // Chain the load straight after the store so the bus sees no idle gap.
            if (R_EN && !dropping) begin
              state    <= RD_REQ;
              BUS_REQ  <= 1'b1;
              BUS_WE   <= 1'b0;
              BUS_ADDR <= R_ADDR;
              BUS_STRB <= '0;
              rd_addr  <= R_ADDR;
            end else begin
              state   <= IDLE;
              BUS_REQ <= 1'b0;
              drop    <= 1'b0;
            end
          end else begin
            drop <= dropping;
          end
        end

        RD_REQ: begin
          drop <= dropping;
          if (BUS_READY) begin
            state   <= RD_RESP;
            BUS_REQ <= 1'b0;
          end
        end

        RD_RESP: begin
          if (BUS_RVALID) begin
            state <= IDLE;
            drop  <= 1'b0;
            if (!dropping) begin
              DATA_RVALID <= 1'b1;
              DATA_RDATA  <= BUS_RDATA;
              DATA_ROADDR <= rd_addr;
            end
          end else begin
            drop <= dropping;
          end
        end

        default: state <= IDLE;
      endcase

      // The pipeline advances on this edge, so the next store is a new one.
      if (!MEM_WAIT) begin
        wr_served <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed scenarios plus randomized pipeline/bus traffic checked
// against a transaction-order model of the arbiter. Revision: 1.0
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst, flush, r_en, w_en, bus_ready, bus_rvalid;
  logic [AW-1:0] r_addr, w_addr;
  logic [SW-1:0] w_strb;
  logic [DW-1:0] w_data, bus_rdata;
  logic          mem_wait, data_rvalid, bus_req, bus_we;
  logic [AW-1:0] data_roaddr, bus_addr;
  logic [DW-1:0] data_rdata, bus_wdata;
  logic [SW-1:0] bus_strb;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RST(rst), .FLUSH(flush),
    .R_EN(r_en), .R_ADDR(r_addr),
    .W_EN(w_en), .W_ADDR(w_addr), .W_STRB(w_strb), .W_DATA(w_data),
    .MEM_WAIT(mem_wait), .DATA_RVALID(data_rvalid),
    .DATA_ROADDR(data_roaddr), .DATA_RDATA(data_rdata),
    .BUS_REQ(bus_req), .BUS_WE(bus_we), .BUS_ADDR(bus_addr),
    .BUS_STRB(bus_strb), .BUS_WDATA(bus_wdata),
    .BUS_READY(bus_ready), .BUS_RVALID(bus_rvalid), .BUS_RDATA(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    step();
    rst = 1'b1; flush = 1'b0; r_en = 1'b0; w_en = 1'b0;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_mem_wait"}, mem_wait, 0);
    check_eq({tag, "_data_rvalid"}, data_rvalid, 0);
    check_eq({tag, "_data_roaddr"}, data_roaddr, 0);
    check_eq({tag, "_data_rdata"}, data_rdata, 0);
    check_eq({tag, "_bus_req"}, bus_req, 0);
    check_eq({tag, "_bus_we"}, bus_we, 0);
    check_eq({tag, "_bus_addr"}, bus_addr, 0);
    check_eq({tag, "_bus_strb"}, bus_strb, 0);
    check_eq({tag, "_bus_wdata"}, bus_wdata, 0);
  endtask

  // Pipeline presents one instruction at a time, holding it while MEM_WAIT=1.
  // Model: each instruction expects its store then its load on the bus, one data
  // pulse per load carrying the slave's data, and completion timing from the rules.
  task automatic run_random(input int n_instr);
    txn_t          exp_q[$];
    txn_t          t;
    int            done = 0, cyc = 0, icyc = 0, wr_acc = -10, rv_seen = 0, resp_delay = -1;
    int            op;
    bit            busy = 1'b0, hold = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic [127:0]  held = '0;
    while (done < n_instr) begin
      step();
      if (!busy) begin
        op     = $urandom_range(0, 3);
        w_en   = op[0];
        r_en   = op[1];
        r_addr = $urandom & 32'hFFFF_FFFC;
        w_addr = $urandom & 32'hFFFF_FFFC;
        w_strb = SW'($urandom_range(1, 15));
        w_data = $urandom;
        if (w_en) begin
          t.we = 1'b1; t.addr = w_addr; t.strb = w_strb; t.data = w_data;
          exp_q.push_back(t);
        end
        if (r_en) begin
          t.we = 1'b0; t.addr = r_addr; t.strb = '0; t.data = '0;
          exp_q.push_back(t);
        end
        busy = 1'b1; icyc = 0; rv_seen = 0;
      end
      bus_ready = ($urandom_range(0, 2) != 0);
      if (resp_delay == 0) begin
        bus_rvalid = 1'b1; bus_rdata = resp_data; resp_delay = -1;
      end else begin
        if (resp_delay > 0) resp_delay--;
        bus_rvalid = (resp_delay < 0) && ($urandom_range(0, 7) == 0);
        bus_rdata  = $urandom;
      end

      smp();
      cyc++; icyc++;
      if (hold) check_eq("rnd_req_hold", {bus_req, bus_we, bus_addr, bus_strb, bus_wdata}, held);
      hold = 1'b0;
      if (bus_req && bus_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rnd_extra_txn", 1, 0);
        end else begin
          t = exp_q.pop_front();
          check_eq("rnd_txn_we", bus_we, t.we);
          check_eq("rnd_txn_addr", bus_addr, t.addr);
          check_eq("rnd_txn_strb", bus_strb, t.strb);
          if (t.we) check_eq("rnd_txn_wdata", bus_wdata, t.data);
        end
        if (bus_we) begin
          wr_acc = cyc;
        end else begin
          resp_delay = $urandom_range(0, 3);
          resp_data  = $urandom;
        end
      end else if (bus_req) begin
        hold = 1'b1;
        held = {bus_req, bus_we, bus_addr, bus_strb, bus_wdata};
      end
      if (data_rvalid) begin
        rv_seen++;
        check_eq("rnd_rv_is_load", r_en, 1);
        check_eq("rnd_roaddr", data_roaddr, r_addr);
        check_eq("rnd_rdata", data_rdata, resp_data);
      end
      if (!mem_wait) begin
        check_eq("rnd_txns_done", exp_q.size(), 0);
        check_eq("rnd_rv_count", rv_seen, r_en ? 1 : 0);
        if (r_en) check_eq("rnd_load_done_rv", data_rvalid, 1);
        else if (w_en) check_eq("rnd_store_lat", cyc - wr_acc, 1);
        busy = 1'b0; done++;
        exp_q.delete();
      end else if (icyc > 64) begin
        check_eq("rnd_timeout", icyc, 0);
        apply_reset();
        exp_q.delete();
        busy = 1'b0; hold = 1'b0; resp_delay = -1; done++;
      end
    end
    step();
    r_en = 1'b0; w_en = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  int rv_cnt;

  initial begin
    rst = 1'b1; flush = 1'b0; r_en = 1'b0; w_en = 1'b0;
    r_addr = '0; w_addr = '0; w_strb = '0; w_data = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    apply_reset();
    smp();
    check_zero("reset");

    // Stray response while idle
    step(); bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    smp();  check_eq("stray_rv0", data_rvalid, 0);
    step(); bus_rvalid = 1'b0;
    smp();  check_eq("stray_rv1", data_rvalid, 0);
    check_eq("stray_rdata", data_rdata, 0);
    check_eq("stray_req", bus_req, 0);

    // Load only, best case
    step(); r_en = 1'b1; r_addr = 32'h0000_1004; bus_ready = 1'b1;
    smp();  check_eq("ld_c0_wait", mem_wait, 1); check_eq("ld_c0_req", bus_req, 0);
    step();
    smp();  check_eq("ld_c1_req", bus_req, 1); check_eq("ld_c1_we", bus_we, 0);
    check_eq("ld_c1_addr", bus_addr, 32'h1004); check_eq("ld_c1_strb", bus_strb, 0);
    check_eq("ld_c1_wait", mem_wait, 1);
    step(); bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    smp();  check_eq("ld_c2_req", bus_req, 0); check_eq("ld_c2_wait", mem_wait, 1);
    check_eq("ld_c2_rv", data_rvalid, 0);
    step(); bus_rvalid = 1'b0;
    smp();  check_eq("ld_c3_rv", data_rvalid, 1); check_eq("ld_c3_rdata", data_rdata, 32'hDEAD_BEEF);
    check_eq("ld_c3_roaddr", data_roaddr, 32'h1004); check_eq("ld_c3_wait", mem_wait, 0);
    step(); r_en = 1'b0; bus_ready = 1'b0;
    smp();  check_eq("ld_c4_rv", data_rvalid, 0); check_eq("ld_c4_req", bus_req, 0);
    check_eq("ld_c4_rdata", data_rdata, 32'hDEAD_BEEF);

    // Store only, READY delayed three cycles
    step(); w_en = 1'b1; w_addr = 32'h2000; w_strb = 4'b0011; w_data = 32'h1234_5678;
    smp();  check_eq("st_c0_wait", mem_wait, 1);
    for (int c = 1; c <= 3; c++) begin
      step(); if (c == 3) bus_ready = 1'b1;
      smp();
      check_eq("st_req", bus_req, 1); check_eq("st_we", bus_we, 1);
      check_eq("st_addr", bus_addr, 32'h2000); check_eq("st_strb", bus_strb, 4'b0011);
      check_eq("st_wdata", bus_wdata, 32'h1234_5678); check_eq("st_wait", mem_wait, 1);
    end
    step(); bus_ready = 1'b0;
    smp();  check_eq("st_done_wait", mem_wait, 0); check_eq("st_done_req", bus_req, 0);
    step(); w_en = 1'b0;
    smp();  check_eq("st_no_reissue", bus_req, 0);

    // Load and store together: store first, load back-to-back
    step(); r_en = 1'b1; r_addr = 32'h10; w_en = 1'b1; w_addr = 32'h20;
    w_strb = 4'hF; w_data = 32'hA5A5_A5A5; bus_ready = 1'b1;
    smp();  check_eq("both_c0_wait", mem_wait, 1); rv_cnt = data_rvalid;
    step();
    smp();  check_eq("both_c1_req", bus_req, 1); check_eq("both_c1_we", bus_we, 1);
    check_eq("both_c1_addr", bus_addr, 32'h20); check_eq("both_c1_wait", mem_wait, 1);
    rv_cnt += data_rvalid;
    step();
    smp();  check_eq("both_c2_req", bus_req, 1); check_eq("both_c2_we", bus_we, 0);
    check_eq("both_c2_addr", bus_addr, 32'h10); check_eq("both_c2_wait", mem_wait, 1);
    rv_cnt += data_rvalid;
    step(); bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
    smp();  check_eq("both_c3_wait", mem_wait, 1); check_eq("both_c3_req", bus_req, 0);
    rv_cnt += data_rvalid;
    step(); bus_rvalid = 1'b0;
    smp();  check_eq("both_c4_rv", data_rvalid, 1); check_eq("both_c4_roaddr", data_roaddr, 32'h10);
    check_eq("both_c4_rdata", data_rdata, 32'h0BAD_F00D); check_eq("both_c4_wait", mem_wait, 0);
    check_eq("both_early_rv", rv_cnt, 0);
    step(); r_en = 1'b0; w_en = 1'b0; bus_ready = 1'b0;
    smp();  check_eq("both_c5_rv", data_rvalid, 0); check_eq("both_c5_req", bus_req, 0);

    // Flush while waiting for the response
    step(); r_en = 1'b1; r_addr = 32'h30; bus_ready = 1'b1;
    smp();
    step();
    smp();  check_eq("fl_req", bus_req, 1); check_eq("fl_addr", bus_addr, 32'h30);
    step(); bus_ready = 1'b0; flush = 1'b1;
    smp();  check_eq("fl_wait_flush", mem_wait, 0);
    step(); flush = 1'b0; r_addr = 32'h40; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    smp();  check_eq("fl_wait_drop", mem_wait, 0); check_eq("fl_no_req", bus_req, 0);
    step(); bus_rvalid = 1'b0;
    smp();  check_eq("fl_no_rv", data_rvalid, 0); check_eq("fl_keep_rdata", data_rdata, 32'h0BAD_F00D);
    check_eq("fl_keep_roaddr", data_roaddr, 32'h10); check_eq("fl_next_wait", mem_wait, 1);
    step(); bus_ready = 1'b1;
    smp();  check_eq("fl_next_req", bus_req, 1); check_eq("fl_next_addr", bus_addr, 32'h40);
    step(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0077;
    smp();
    step(); bus_rvalid = 1'b0;
    smp();  check_eq("fl_next_rv", data_rvalid, 1); check_eq("fl_next_rdata", data_rdata, 32'h77);
    check_eq("fl_next_roaddr", data_roaddr, 32'h40); check_eq("fl_next_done", mem_wait, 0);
    step(); r_en = 1'b0;
    smp();

    // Reset in the middle of an unaccepted read
    step(); r_en = 1'b1; r_addr = 32'h50; bus_ready = 1'b0;
    smp();
    step(); rst = 1'b1; r_en = 1'b0;
    smp();  check_eq("rs_req_before", bus_req, 1);
    step(); rst = 1'b0;
    smp();  check_zero("rs");
    step();
    smp();  check_eq("rs_idle_req", bus_req, 0);

    run_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
